// File: rtl/jk_drive_if.sv
// Handshake and data bundle between the JK drive sequencer and the bench or
// harness around it. The sequencer sits on the master side.
interface jk_drive_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             q_in;
  logic [1:0]       jk;
  logic             q_expect;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [CW-1:0]    err_count;

  modport master (
    input  start, pattern, q_in,
    output jk, q_expect, busy, done, mismatch, err_count
  );

  modport slave (
    output start, pattern, q_in,
    input  jk, q_expect, busy, done, mismatch, err_count
  );
endinterface

// File: rtl/jk_drive_sequencer.sv
// Drives a JK flip-flop through a target q pattern (LSB first) using the
// excitation table, then checks the returned q two cycles later.
module jk_drive_sequencer #(
  parameter int WIDTH       = 8,
  parameter int CW          = 4,
  parameter int TOGGLE_PREF = 0
) (
  input  logic      clk,
  input  logic      rst,
  jk_drive_if.master bus
);

  localparam int CNT_W = $clog2(WIDTH + 3);

  typedef enum logic [1:0] {IDLE, PRIME, DRIVE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       jk_q, jk_d;
  logic             qe_q, qe_d;
  logic             exp_d1_q, exp_d1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [CW-1:0]    err_q, err_d;
  logic             cmp_en;

  function automatic logic [1:0] excite(input logic prev, input logic next);
    if (prev == next)          return 2'b00;
    else if (TOGGLE_PREF != 0) return 2'b11;
    else if (next)             return 2'b10;
    else                       return 2'b01;
  endfunction

  // NOTE: every _d gets its hold value first, so no path through the case
  // below can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    jk_d       = jk_q;
    qe_d       = qe_q;
    exp_d1_d   = qe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    err_d      = err_q;

    // cnt_q holds the index n of the upcoming edge E_n while a run is active.
    cmp_en = (state_q != IDLE) && (cnt_q >= CNT_W'(2));
    if (cmp_en && (bus.q_in != exp_d1_q)) begin
      mismatch_d = 1'b1;
      if (err_q != '1) err_d = err_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        jk_d = 2'b00;
        if (bus.start) begin
          pat_d      = bus.pattern;
          mismatch_d = 1'b0;
          err_d      = '0;
          busy_d     = 1'b1;
          jk_d       = 2'b01;
          qe_d       = 1'b0;
          cnt_d      = CNT_W'(1);
          state_d    = PRIME;
        end
      end
      PRIME, DRIVE: begin
        // q_expect still carries the previously issued bit, i.e. the "prev" q.
        jk_d    = excite(qe_q, pat_q[0]);
        qe_d    = pat_q[0];
        pat_d   = pat_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(WIDTH)) ? DRAIN : DRIVE;
      end
      DRAIN: begin
        jk_d  = 2'b00;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH + 2)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      cnt_q      <= '0;
      jk_q       <= 2'b00;
      qe_q       <= 1'b0;
      exp_d1_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      jk_q       <= jk_d;
      qe_q       <= qe_d;
      exp_d1_q   <= exp_d1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign bus.jk        = jk_q;
  assign bus.q_expect  = qe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_q;

endmodule
